// File: rtl/sdram_arb_pkg.sv
// Shared types for the SDRAM command arbiter: owner IDs, FSM states, tag width.
package sdram_arb_pkg;

    localparam int TAG_W = 2;

    typedef enum logic [TAG_W-1:0] {
        OWN_FB = 2'd0,
        OWN_IB = 2'd1,
        OWN_DB = 2'd2
    } owner_e;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_e;

    // Successor in the fb -> ib -> db ring.
    function automatic owner_e next_owner(input owner_e o);
        case (o)
            OWN_FB:  next_owner = OWN_IB;
            OWN_IB:  next_owner = OWN_DB;
            default: next_owner = OWN_FB;
        endcase
    endfunction

endpackage

// File: rtl/sdram_arb_tagfifo.sv
// Owner-tag FIFO for outstanding SDRAM reads; DEPTH must be a power of two >= 2.
module sdram_arb_tagfifo
    import sdram_arb_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [TAG_W-1:0] din,
    output logic [TAG_W-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full
);

    localparam int PW = $clog2(DEPTH);

    logic [TAG_W-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop in the same cycle makes room, so a push into a full FIFO is still taken.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/sdram_arbiter.sv
// Three-port (fb/ib/db) arbiter onto one SDRAM controller command port.
// Define SDRAM_ARB_FB_PRIO_EN for fixed fb priority; default is fair fb/ib/db round-robin.
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W    = 24,
    parameter int DATA_W    = 16,
    parameter int TAG_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fb_req,
    input  logic [ADDR_W-1:0] fb_addr,
    output logic              fb_ack,
    output logic              fb_rvalid,
    input  logic              ib_req,
    input  logic [ADDR_W-1:0] ib_addr,
    output logic              ib_ack,
    output logic              ib_rvalid,
    input  logic              db_req,
    input  logic              db_we,
    input  logic [ADDR_W-1:0] db_addr,
    input  logic [DATA_W-1:0] db_wdata,
    input  logic [1:0]        db_wmask,
    output logic              db_ack,
    output logic              db_rvalid,
    output logic [DATA_W-1:0] rd_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [1:0]        mem_wmask,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err_unexp
);

    localparam int CW = $clog2(TAG_DEPTH + 1);

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [1:0]        wmask;
    } cmd_t;

    state_e           state_q, state_d;
    owner_e           owner_q;
    owner_e           rr_q, rr_next;
    owner_e           grant, cand;
    logic             grant_vld;
    logic [2:0]       elig;
    logic             rd_ok;
    cmd_t             cmd_q, cmd_d;
    logic             accept;

    logic             tag_push;
    logic             tag_pop;
    logic [TAG_W-1:0] tag_dout;
    logic [CW-1:0]    tag_count;
    logic             tag_empty;
    logic             tag_full;
    logic             ret_ok;

    // Registered count only: a pop in this IDLE cycle does not open a read slot until next cycle.
    assign rd_ok          = (tag_count < CW'(TAG_DEPTH));
    assign elig[OWN_FB]   = fb_req && rd_ok;
    assign elig[OWN_IB]   = ib_req && rd_ok;
    assign elig[OWN_DB]   = db_req && (db_we || rd_ok);

`ifdef SDRAM_ARB_FB_PRIO_EN
    always_comb begin
        grant     = OWN_FB;
        grant_vld = 1'b0;
        cand      = rr_q;
        rr_next   = rr_q;
        if (elig[OWN_FB]) begin
            grant     = OWN_FB;
            grant_vld = 1'b1;
        end else if (rr_q == OWN_IB && elig[OWN_IB]) begin
            grant     = OWN_IB;
            grant_vld = 1'b1;
        end else if (elig[OWN_DB]) begin
            grant     = OWN_DB;
            grant_vld = 1'b1;
        end else if (elig[OWN_IB]) begin
            grant     = OWN_IB;
            grant_vld = 1'b1;
        end
        // fb grants leave the ib/db pointer alone.
        if (grant_vld && grant == OWN_IB) rr_next = OWN_DB;
        if (grant_vld && grant == OWN_DB) rr_next = OWN_IB;
    end
`else
    always_comb begin
        grant     = OWN_FB;
        grant_vld = 1'b0;
        cand      = rr_q;
        for (int i = 0; i < 3; i++) begin
            if (!grant_vld && elig[cand]) begin
                grant     = cand;
                grant_vld = 1'b1;
            end
            cand = next_owner(cand);
        end
        rr_next = next_owner(grant);
    end
`endif

    always_comb begin
        cmd_d = '0;
        case (grant)
            OWN_FB: cmd_d.addr = fb_addr;
            OWN_IB: cmd_d.addr = ib_addr;
            default: begin
                cmd_d.we    = db_we;
                cmd_d.addr  = db_addr;
                cmd_d.wdata = db_wdata;
                cmd_d.wmask = db_wmask;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_vld) state_d = ISSUE;
            ISSUE:   if (mem_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= OWN_FB;
            cmd_q   <= '0;
            rr_q    <= OWN_IB;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && grant_vld) begin
                owner_q <= grant;
                cmd_q   <= cmd_d;
                rr_q    <= rr_next;
            end
        end
    end

    assign mem_req   = (state_q == ISSUE);
    assign mem_we    = cmd_q.we;
    assign mem_addr  = cmd_q.addr;
    assign mem_wdata = cmd_q.wdata;
    assign mem_wmask = cmd_q.wmask;

    assign accept = mem_req && mem_ready;
    assign fb_ack = accept && owner_q == OWN_FB;
    assign ib_ack = accept && owner_q == OWN_IB;
    assign db_ack = accept && owner_q == OWN_DB;

    // Eligibility keeps reads below depth, so the full gate never drops a real tag.
    assign tag_push = accept && !cmd_q.we && !tag_full;
    assign tag_pop  = mem_rvalid;
    assign ret_ok   = mem_rvalid && !tag_empty;

    sdram_arb_tagfifo #(.DEPTH(TAG_DEPTH)) u_tagfifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tag_push),
        .pop   (tag_pop),
        .din   (owner_q),
        .dout  (tag_dout),
        .count (tag_count),
        .empty (tag_empty),
        .full  (tag_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            fb_rvalid <= 1'b0;
            ib_rvalid <= 1'b0;
            db_rvalid <= 1'b0;
            rd_data   <= '0;
            err_unexp <= 1'b0;
        end else begin
            fb_rvalid <= ret_ok && tag_dout == OWN_FB;
            ib_rvalid <= ret_ok && tag_dout == OWN_IB;
            db_rvalid <= ret_ok && tag_dout == OWN_DB;
            if (ret_ok) rd_data <= mem_rdata;
            if (mem_rvalid && tag_empty) err_unexp <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Scoreboard bench for sdram_arbiter: expected commands/returns queued by stimulus, checked by a monitor.
module tb_sdram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        fb_req, ib_req, db_req, db_we;
    logic [23:0] fb_addr, ib_addr, db_addr;
    logic [15:0] db_wdata;
    logic [1:0]  db_wmask;
    logic        fb_ack, ib_ack, db_ack;
    logic        fb_rvalid, ib_rvalid, db_rvalid;
    logic [15:0] rd_data;
    logic        mem_req, mem_we;
    logic [23:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [1:0]  mem_wmask;
    logic        mem_ready, mem_rvalid;
    logic [15:0] mem_rdata;
    logic        err_unexp;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [2:0]  ack;
        logic        we;
        logic [23:0] addr;
        logic [15:0] wdata;
        logic [1:0]  wmask;
    } exp_cmd_t;

    typedef struct {
        logic [2:0]  rv;
        logic [15:0] data;
    } exp_rd_t;

    exp_cmd_t exp_cmd[$];
    exp_rd_t  exp_rd[$];

    sdram_arbiter #(.ADDR_W(24), .DATA_W(16), .TAG_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .fb_req(fb_req), .fb_addr(fb_addr), .fb_ack(fb_ack), .fb_rvalid(fb_rvalid),
        .ib_req(ib_req), .ib_addr(ib_addr), .ib_ack(ib_ack), .ib_rvalid(ib_rvalid),
        .db_req(db_req), .db_we(db_we), .db_addr(db_addr), .db_wdata(db_wdata),
        .db_wmask(db_wmask), .db_ack(db_ack), .db_rvalid(db_rvalid),
        .rd_data(rd_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .err_unexp(err_unexp)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic exp_c(input logic [2:0] ack, input logic we, input logic [23:0] addr,
                         input logic [15:0] wdata, input logic [1:0] wmask);
        exp_cmd_t e;
        e.ack = ack; e.we = we; e.addr = addr; e.wdata = wdata; e.wmask = wmask;
        exp_cmd.push_back(e);
    endtask

    task automatic exp_r(input logic [2:0] rv, input logic [15:0] data);
        exp_rd_t e;
        e.rv = rv; e.data = data;
        exp_rd.push_back(e);
    endtask

    // Monitor: every accepted command and every read return is matched against the queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_req && mem_ready) begin
                if (exp_cmd.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL cmd_unexpected: got ack=%b addr=%h we=%b, expected no command",
                             {db_ack, ib_ack, fb_ack}, mem_addr, mem_we);
                end else begin
                    exp_cmd_t e;
                    e = exp_cmd.pop_front();
                    check("cmd", {{db_ack, ib_ack, fb_ack}, mem_we, mem_addr,
                                  mem_we ? mem_wdata : 16'h0, mem_we ? mem_wmask : 2'b0},
                                 {e.ack, e.we, e.addr, e.we ? e.wdata : 16'h0, e.we ? e.wmask : 2'b0});
                end
            end else if (fb_ack || ib_ack || db_ack) begin
                checks++; failures++;
                $display("FAIL ack_no_accept: got ack=%b, expected no ack", {db_ack, ib_ack, fb_ack});
            end
            if (fb_rvalid || ib_rvalid || db_rvalid) begin
                if (exp_rd.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL rd_unexpected: got rvalid=%b data=%h, expected no return",
                             {db_rvalid, ib_rvalid, fb_rvalid}, rd_data);
                end else begin
                    exp_rd_t r;
                    r = exp_rd.pop_front();
                    check("rd", {{db_rvalid, ib_rvalid, fb_rvalid}, rd_data}, {r.rv, r.data});
                end
            end
        end
    end

    function automatic logic ack_of(input int p);
        case (p)
            0:       return fb_ack;
            1:       return ib_ack;
            default: return db_ack;
        endcase
    endfunction

    task automatic set_port(input int p, input logic req, input logic we, input logic [23:0] addr,
                            input logic [15:0] wdata, input logic [1:0] wmask);
        case (p)
            0: begin fb_req = req; fb_addr = addr; end
            1: begin ib_req = req; ib_addr = addr; end
            default: begin
                db_req = req; db_we = we; db_addr = addr; db_wdata = wdata; db_wmask = wmask;
            end
        endcase
    endtask

    task automatic wait_ack(input int p);
        bit ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (ack_of(p)) ok = 1'b1;
        end
        check("ack_wait", 64'(ok), 64'd1);
    endtask

    // Holds req high across n back-to-back commands, bumping the address after each ack.
    task automatic req_seq(input int p, input int n, input logic [23:0] base, input logic we,
                           input logic [15:0] wdata, input logic [1:0] wmask);
        for (int k = 0; k < n; k++) begin
            set_port(p, 1'b1, we, base + 24'(k), wdata, wmask);
            wait_ack(p);
            @(posedge clk); #1;
        end
        set_port(p, 1'b0, we, base, wdata, wmask);
    endtask

    // Caller is aligned just after a rising edge; one-cycle mem_rvalid pulse.
    task automatic ret(input logic [15:0] data, input logic exp_any);
        mem_rvalid = 1'b1;
        mem_rdata  = data;
        @(negedge clk);
        check("ret_lat0", 64'(fb_rvalid | ib_rvalid | db_rvalid), 64'd0);
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        @(negedge clk);
        check("ret_lat1", 64'(fb_rvalid | ib_rvalid | db_rvalid), 64'(exp_any));
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        for (int p = 0; p < 3; p++) set_port(p, 1'b0, 1'b0, 24'h0, 16'h0, 2'b0);
        mem_rvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        for (int p = 0; p < 3; p++) set_port(p, 1'b0, 1'b0, 24'h0, 16'h0, 2'b0);
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 16'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mem", {mem_req, mem_we, mem_wmask, mem_wdata, mem_addr}, 64'd0);
        check("rst_ack_rv", {fb_ack, ib_ack, db_ack, fb_rvalid, ib_rvalid, db_rvalid}, 64'd0);
        check("rst_rd_err", {err_unexp, rd_data}, 64'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Single ib read, controller always ready.
        mem_ready = 1'b1;
        @(posedge clk); #1;
        exp_c(3'b010, 1'b0, 24'h000100, 16'h0, 2'b0);
        set_port(1, 1'b1, 1'b0, 24'h000100, 16'h0, 2'b0);
        @(negedge clk);
        check("t1_idle_bubble", 64'(mem_req), 64'd0);
        @(negedge clk);
        check("t1_req_ack", {mem_req, ib_ack}, 64'b11);
        @(posedge clk); #1;
        set_port(1, 1'b0, 1'b0, 24'h000100, 16'h0, 2'b0);
        repeat (2) begin @(posedge clk); #1; end
        exp_r(3'b010, 16'hBEEF);
        ret(16'hBEEF, 1'b1);

        // All three ports requesting continuously.
        do_reset();
        mem_ready = 1'b1;
`ifdef SDRAM_ARB_FB_PRIO_EN
        exp_c(3'b001, 1'b0, 24'h10, 16'h0, 2'b0);
        exp_c(3'b001, 1'b0, 24'h11, 16'h0, 2'b0);
        exp_c(3'b010, 1'b0, 24'h20, 16'h0, 2'b0);
        exp_c(3'b100, 1'b1, 24'h30, 16'hD00D, 2'b11);
        exp_c(3'b010, 1'b0, 24'h21, 16'h0, 2'b0);
        exp_c(3'b100, 1'b1, 24'h31, 16'hD00D, 2'b11);
`else
        exp_c(3'b010, 1'b0, 24'h20, 16'h0, 2'b0);
        exp_c(3'b100, 1'b1, 24'h30, 16'hD00D, 2'b11);
        exp_c(3'b001, 1'b0, 24'h10, 16'h0, 2'b0);
        exp_c(3'b010, 1'b0, 24'h21, 16'h0, 2'b0);
        exp_c(3'b100, 1'b1, 24'h31, 16'hD00D, 2'b11);
        exp_c(3'b001, 1'b0, 24'h11, 16'h0, 2'b0);
`endif
        @(posedge clk); #1;
        fork
            req_seq(0, 2, 24'h10, 1'b0, 16'h0, 2'b0);
            req_seq(1, 2, 24'h20, 1'b0, 16'h0, 2'b0);
            req_seq(2, 2, 24'h30, 1'b1, 16'hD00D, 2'b11);
        join
`ifdef SDRAM_ARB_FB_PRIO_EN
        exp_r(3'b001, 16'hA001); exp_r(3'b001, 16'hA002);
        exp_r(3'b010, 16'hA003); exp_r(3'b010, 16'hA004);
`else
        exp_r(3'b010, 16'hA001); exp_r(3'b001, 16'hA002);
        exp_r(3'b010, 16'hA003); exp_r(3'b001, 16'hA004);
`endif
        for (int k = 1; k <= 4; k++) ret(16'hA000 + 16'(k), 1'b1);

        // db write held off by mem_ready low for 5 cycles.
        do_reset();
        mem_ready = 1'b0;
        @(posedge clk); #1;
        exp_c(3'b100, 1'b1, 24'h00ABCD, 16'h1234, 2'b10);
        set_port(2, 1'b1, 1'b1, 24'h00ABCD, 16'h1234, 2'b10);
        @(negedge clk);
        check("t3_idle_bubble", 64'(mem_req), 64'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t3_hold", {mem_req, mem_we, mem_wmask, mem_wdata, mem_addr, db_ack},
                  {1'b1, 1'b1, 2'b10, 16'h1234, 24'h00ABCD, 1'b0});
        end
        @(posedge clk); #1 mem_ready = 1'b1;
        wait_ack(2);
        @(posedge clk); #1;
        set_port(2, 1'b0, 1'b1, 24'h00ABCD, 16'h1234, 2'b10);

        // Fill the tag FIFO with fb reads (the write above must not hold a slot).
        for (int k = 0; k < 4; k++) exp_c(3'b001, 1'b0, 24'h40 + 24'(k), 16'h0, 2'b0);
        req_seq(0, 4, 24'h40, 1'b0, 16'h0, 2'b0);
        exp_c(3'b100, 1'b1, 24'h5000, 16'h7777, 2'b11);
        set_port(0, 1'b1, 1'b0, 24'h44, 16'h0, 2'b0);
        set_port(2, 1'b1, 1'b1, 24'h5000, 16'h7777, 2'b11);
        wait_ack(2);
        @(posedge clk); #1;
        set_port(2, 1'b0, 1'b1, 24'h5000, 16'h7777, 2'b11);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t4_full_block", {mem_req, fb_ack}, 64'd0);
        end
        @(posedge clk); #1;
        exp_c(3'b001, 1'b0, 24'h44, 16'h0, 2'b0);
        exp_r(3'b001, 16'hF001);
        mem_rvalid = 1'b1; mem_rdata = 16'hF001;
        @(negedge clk);
        check("t4_pop_no_free", 64'(mem_req), 64'd0);
        @(posedge clk); #1 mem_rvalid = 1'b0;
        @(negedge clk);
        check("t4_idle_after_pop", {mem_req, fb_rvalid}, 64'b01);
        wait_ack(0);
        @(posedge clk); #1;
        set_port(0, 1'b0, 1'b0, 24'h44, 16'h0, 2'b0);
        for (int k = 2; k <= 5; k++) begin
            exp_r(3'b001, 16'hF000 + 16'(k));
            ret(16'hF000 + 16'(k), 1'b1);
        end

        // Interleaved reads from all three ports, returns routed in command order.
        do_reset();
        mem_ready = 1'b1;
        @(posedge clk); #1;
        exp_c(3'b010, 1'b0, 24'h200, 16'h0, 2'b0);
        req_seq(1, 1, 24'h200, 1'b0, 16'h0, 2'b0);
        exp_c(3'b001, 1'b0, 24'h201, 16'h0, 2'b0);
        req_seq(0, 1, 24'h201, 1'b0, 16'h0, 2'b0);
        exp_c(3'b100, 1'b0, 24'h202, 16'h0, 2'b0);
        req_seq(2, 1, 24'h202, 1'b0, 16'h0, 2'b0);
        exp_r(3'b010, 16'h0001); exp_r(3'b001, 16'h0002); exp_r(3'b100, 16'h0003);
        for (int k = 1; k <= 3; k++) ret(16'(k), 1'b1);

        // Return with nothing outstanding, then reset in the middle of a command.
        check("t6_err_clear", 64'(err_unexp), 64'd0);
        ret(16'hDEAD, 1'b0);
        check("t6_err_set", 64'(err_unexp), 64'd1);
        repeat (3) begin @(posedge clk); #1; end
        check("t6_err_sticky", 64'(err_unexp), 64'd1);
        exp_c(3'b010, 1'b0, 24'h300, 16'h0, 2'b0);
        req_seq(1, 1, 24'h300, 1'b0, 16'h0, 2'b0);
        mem_ready = 1'b0;
        set_port(1, 1'b1, 1'b0, 24'h301, 16'h0, 2'b0);
        @(negedge clk);
        @(negedge clk);
        check("t6_issue_held", 64'(mem_req), 64'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        set_port(1, 1'b0, 1'b0, 24'h301, 16'h0, 2'b0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("t6_rst_drop", {mem_req, err_unexp}, 64'd0);
        mem_ready = 1'b1;
        @(posedge clk); #1;
        ret(16'hBAD0, 1'b0);
        check("t6_tags_discarded", 64'(err_unexp), 64'd1);

        repeat (2) @(posedge clk);
        check("sb_empty", 64'(exp_cmd.size() + exp_rd.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
